vdma_axi4s_pattern_master: RTL and testbench



---
 rtl/vdma_axi4s_pattern_master_if.sv | 42 ++++
 rtl/vdma_axi4s_pattern_master.sv | 235 +++++++++++++++++++++++
 tb/tb_vdma_axi4s_pattern_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdma_axi4s_pattern_master_if.sv
`default_nettype none
// ============================================================================
// Module      : vdma_axi4s_pattern_master_if
// Description : AXI4-Stream video bus carried between the pattern master and
//               its sink. The master drives tdata/tuser/tlast/tvalid; the
//               slave drives tready.
// Parameters  : DATA_WIDTH - tdata width
//               USER_WIDTH - tuser width (bit 0 = start of frame)
// Signals     : tdata  - pixel
//               tuser  - start of frame
//               tlast  - end of line
//               tvalid - beat valid
//               tready - beat ready
// Revision    : 1.0 - initial release
// ============================================================================
interface vdma_axi4s_pattern_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tuser,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tuser,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/vdma_axi4s_pattern_master.sv
`default_nettype none
// ============================================================================
// Module      : vdma_axi4s_pattern_master
// Description : AXI4-Stream video test-pattern source. Emits frames of
//               param_width x param_height pixels, one beat per cycle while
//               tready is high, in one of four patterns (pixel counter,
//               {y,x} coordinate, solid colour, checkerboard).
// Build macro : VDMA_PATTERN_GAP_EN - when defined, inserts param_h_gap idle
//               cycles after every line (GAP state); when undefined, lines
//               run back-to-back and param_h_gap is ignored.
// Ports       : aclk, areset         - clock, async active-high reset
//               ctl_enable           - run frames
//               ctl_update           - latch param_* at frame start
//               ctl_busy             - frame in progress
//               ctl_index            - completed-frame count
//               param_width/height   - frame geometry
//               param_mode/color     - pattern select / solid colour
//               param_h_gap          - idle cycles after each line
//               m_axi4s              - AXI4-Stream master bus
// Revision    : 1.0 - initial release
// ============================================================================
module vdma_axi4s_pattern_master #(
  parameter int AXI4S_DATA_WIDTH = 32,
  parameter int AXI4S_USER_WIDTH = 1,
  parameter int H_WIDTH          = 12,
  parameter int V_WIDTH          = 12,
  parameter int INDEX_WIDTH      = 8,
  parameter int CHECKER_SHIFT    = 4
) (
  input  wire                          aclk,
  input  wire                          areset,
  input  wire                          ctl_enable,
  input  wire                          ctl_update,
  output logic                         ctl_busy,
  output logic [INDEX_WIDTH-1:0]       ctl_index,
  input  wire  [H_WIDTH-1:0]           param_width,
  input  wire  [V_WIDTH-1:0]           param_height,
  input  wire  [1:0]                   param_mode,
  input  wire  [AXI4S_DATA_WIDTH-1:0]  param_color,
  input  wire  [H_WIDTH-1:0]           param_h_gap,
  vdma_axi4s_pattern_master_if.master  m_axi4s
);

  localparam int DW = AXI4S_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1
`ifdef VDMA_PATTERN_GAP_EN
    , S_GAP  = 2'd2
`endif
  } state_t;

  state_t                  state_q;
  logic [H_WIDTH-1:0]      width_q;
  logic [V_WIDTH-1:0]      height_q;
  logic [1:0]              mode_q;
  logic [DW-1:0]           color_q;
  logic [H_WIDTH-1:0]      x_q;
  logic [V_WIDTH-1:0]      y_q;
  logic [DW-1:0]           pix_q;
  logic [DW-1:0]           tdata_q;
  logic [AXI4S_USER_WIDTH-1:0] tuser_q;
  logic                    tlast_q;
  logic                    tvalid_q;
  logic [INDEX_WIDTH-1:0]  index_q;
`ifdef VDMA_PATTERN_GAP_EN
  logic [H_WIDTH-1:0]      hgap_q;
  logic [H_WIDTH-1:0]      gap_cnt_q;
  logic                    frame_done_q;  // gap follows the frame's last line
  logic                    gap_entry;
  logic                    gap_exit;
`else
  wire                     unused_h_gap = ^param_h_gap;
`endif

  // Pixel value for a position under a given pattern mode.
  function automatic logic [DW-1:0] f_pattern(
    input logic [1:0]         mode,
    input logic [H_WIDTH-1:0] x,
    input logic [V_WIDTH-1:0] y,
    input logic [DW-1:0]      pix,
    input logic [DW-1:0]      color
  );
    logic [H_WIDTH+V_WIDTH+DW-1:0] yx;
    // Padding above {y,x} gives zero-extension or truncation for any DW.
    yx = {{DW{1'b0}}, y, x};
    case (mode)
      2'd0:    f_pattern = pix;
      2'd1:    f_pattern = yx[DW-1:0];
      2'd2:    f_pattern = color;
      default: f_pattern = (x[CHECKER_SHIFT] ^ y[CHECKER_SHIFT]) ? '1 : '0;
    endcase
  endfunction

  logic [H_WIDTH-1:0] eff_width;
  logic [V_WIDTH-1:0] eff_height;
  logic [1:0]         eff_mode;
  logic [DW-1:0]      eff_color;
  logic               start_ok, accept, last_x, last_y, frame_end;
  logic               seq_end, do_launch, do_idle;
  logic [H_WIDTH-1:0] x_d;
  logic [V_WIDTH-1:0] y_d;
  logic [DW-1:0]      pix_d, cont_data, launch_data;
  logic               cont_last, launch_last;

  always_comb begin
    // A frame start sees the pins when updating, otherwise the held set.
    eff_width   = ctl_update ? param_width  : width_q;
    eff_height  = ctl_update ? param_height : height_q;
    eff_mode    = ctl_update ? param_mode   : mode_q;
    eff_color   = ctl_update ? param_color  : color_q;
    start_ok    = ctl_enable && (eff_width != '0) && (eff_height != '0);

    accept      = tvalid_q && m_axi4s.tready;
    last_x      = (x_q == width_q - H_WIDTH'(1));
    last_y      = (y_q == height_q - V_WIDTH'(1));
    frame_end   = last_x && last_y;

    x_d         = last_x ? '0 : x_q + H_WIDTH'(1);
    y_d         = last_x ? y_q + V_WIDTH'(1) : y_q;
    pix_d       = pix_q + DW'(1);
    cont_data   = f_pattern(mode_q, x_d, y_d, pix_d, color_q);
    cont_last   = (x_d == width_q - H_WIDTH'(1));
    launch_data = f_pattern(eff_mode, '0, '0, '0, eff_color);
    launch_last = (eff_width == H_WIDTH'(1));

`ifdef VDMA_PATTERN_GAP_EN
    gap_entry   = (state_q == S_ACTIVE) && accept && last_x && (hgap_q != '0);
    gap_exit    = (state_q == S_GAP) && (gap_cnt_q == H_WIDTH'(1));
    seq_end     = ((state_q == S_ACTIVE) && accept && frame_end && !gap_entry) ||
                  (gap_exit && frame_done_q);
`else
    seq_end     = (state_q == S_ACTIVE) && accept && frame_end;
`endif
    // Frame boundary: restart immediately when enabled, else go idle.
    do_launch   = start_ok && ((state_q == S_IDLE) || seq_end);
    do_idle     = seq_end && !start_ok;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      mode_q       <= '0;
      color_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pix_q        <= '0;
      tdata_q      <= '0;
      tuser_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      index_q      <= '0;
`ifdef VDMA_PATTERN_GAP_EN
      hgap_q       <= '0;
      gap_cnt_q    <= '0;
      frame_done_q <= 1'b0;
`endif
    end else begin
      if (accept && frame_end) begin
        index_q <= index_q + INDEX_WIDTH'(1);
      end

      if (do_launch) begin
        state_q <= S_ACTIVE;
        if (ctl_update) begin
          width_q  <= param_width;
          height_q <= param_height;
          mode_q   <= param_mode;
          color_q  <= param_color;
`ifdef VDMA_PATTERN_GAP_EN
          hgap_q   <= param_h_gap;
`endif
        end
        x_q      <= '0;
        y_q      <= '0;
        pix_q    <= '0;
        tdata_q  <= launch_data;
        tuser_q  <= AXI4S_USER_WIDTH'(1'b1);
        tlast_q  <= launch_last;
        tvalid_q <= 1'b1;
      end else if (do_idle) begin
        state_q  <= S_IDLE;
        tdata_q  <= '0;
        tuser_q  <= '0;
        tlast_q  <= 1'b0;
        tvalid_q <= 1'b0;
      end else begin
        case (state_q)
          S_ACTIVE: begin
            if (accept) begin
              x_q     <= x_d;
              y_q     <= y_d;
              pix_q   <= pix_d;
              tdata_q <= cont_data;
              tuser_q <= '0;
              tlast_q <= cont_last;
`ifdef VDMA_PATTERN_GAP_EN
              // Next beat is preloaded; only tvalid waits out the gap.
              if (gap_entry) begin
                state_q      <= S_GAP;
                gap_cnt_q    <= hgap_q;
                frame_done_q <= frame_end;
                tvalid_q     <= 1'b0;
              end
`endif
            end
          end
`ifdef VDMA_PATTERN_GAP_EN
          S_GAP: begin
            if (gap_exit) begin
              state_q  <= S_ACTIVE;
              tvalid_q <= 1'b1;
            end else begin
              gap_cnt_q <= gap_cnt_q - H_WIDTH'(1);
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign ctl_busy       = (state_q != S_IDLE);
  assign ctl_index      = index_q;
  assign m_axi4s.tdata  = tdata_q;
  assign m_axi4s.tuser  = tuser_q;
  assign m_axi4s.tlast  = tlast_q;
  assign m_axi4s.tvalid = tvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_vdma_axi4s_pattern_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdma_axi4s_pattern_master
// Description : Self-checking bench for vdma_axi4s_pattern_master. A frame
//               model expands each requested frame into the expected beat
//               sequence (and idle gap cycles when VDMA_PATTERN_GAP_EN is
//               defined); the DUT stream is compared against it cycle by
//               cycle with randomised tready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdma_axi4s_pattern_master;

  localparam int DW = 32;
  localparam int UW = 1;
  localparam int HW = 12;
  localparam int VW = 12;
  localparam int IW = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic          ctl_enable;
  logic          ctl_update;
  logic          ctl_busy;
  logic [IW-1:0] ctl_index;
  logic [HW-1:0] param_width;
  logic [VW-1:0] param_height;
  logic [1:0]    param_mode;
  logic [DW-1:0] param_color;
  logic [HW-1:0] param_h_gap;

  vdma_axi4s_pattern_master_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

  vdma_axi4s_pattern_master #(
    .AXI4S_DATA_WIDTH(DW), .AXI4S_USER_WIDTH(UW), .H_WIDTH(HW),
    .V_WIDTH(VW), .INDEX_WIDTH(IW), .CHECKER_SHIFT(4)
  ) dut (
    .aclk(aclk), .areset(areset),
    .ctl_enable(ctl_enable), .ctl_update(ctl_update),
    .ctl_busy(ctl_busy), .ctl_index(ctl_index),
    .param_width(param_width), .param_height(param_height),
    .param_mode(param_mode), .param_color(param_color),
    .param_h_gap(param_h_gap),
    .m_axi4s(bus)
  );

  always #5 aclk = ~aclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          gap;   // expected idle cycle
    logic [31:0] data;
    bit          user;
    bit          last;
    bit          eof;   // last beat of a frame
  } beat_t;

  beat_t      q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_idx;
  bit         gap_build;
  int         lat_w, lat_h, lat_mode, lat_gap;
  logic [31:0] lat_color;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected beats of one frame, straight from the pattern definitions.
  task automatic push_frame(input int w, input int h, input int mode,
                            input logic [31:0] color, input int hgap);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        beat_t b;
        b.gap  = 1'b0;
        b.user = (x == 0 && y == 0);
        b.last = (x == w - 1);
        b.eof  = b.last && (y == h - 1);
        case (mode)
          0:       b.data = 32'(y * w + x);
          1:       b.data = 32'((y % 4096) * 4096 + (x % 4096));
          2:       b.data = color;
          default: b.data = ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
        endcase
        q.push_back(b);
      end
      if (gap_build) begin
        for (int g = 0; g < hgap; g++) begin
          beat_t e;
          e = '{gap: 1'b1, data: 32'h0, user: 1'b0, last: 1'b0, eof: 1'b0};
          q.push_back(e);
        end
      end
    end
  endtask

  // Drive a start request for one clock; enable stays high when hold=1.
  task automatic start(input int w, input int h, input int mode, input logic [31:0] color,
                       input int hgap, input bit upd, input bit hold, input int nf);
    param_width  = HW'(w);
    param_height = VW'(h);
    param_mode   = 2'(mode);
    param_color  = color;
    param_h_gap  = HW'(hgap);
    ctl_update   = upd;
    ctl_enable   = 1'b1;
    bus.tready   = 1'b1;
    if (upd) begin
      lat_w = w; lat_h = h; lat_mode = mode; lat_color = color; lat_gap = hgap;
    end
    for (int f = 0; f < nf; f++) push_frame(lat_w, lat_h, lat_mode, lat_color, lat_gap);
    @(negedge aclk);
    ctl_update = 1'b0;
    if (!hold) ctl_enable = 1'b0;
  endtask

  // Consume the expected queue against the DUT stream, one cycle per step.
  task automatic run(input int max_cycles, input bit rnd, input int drop_after,
                     input int stop_after);
    int          cyc = 0;
    int          pops = 0;
    bit          pend = 1'b0;
    bit          pv = 1'b0;
    bit          pr = 1'b0;
    bit          rdy;
    logic [31:0] pd = '0;
    logic        pu = 1'b0;
    logic        pl = 1'b0;
    while (q.size() != 0 && cyc < max_cycles) begin
      if (pops == stop_after) return;
      if (pops == drop_after) ctl_enable = 1'b0;
      chk("ctl_index", 64'(ctl_index), 64'(exp_idx));
      if (pv && !pr)
        chk("stall_hold", 64'({bus.tvalid, bus.tdata, bus.tuser, bus.tlast}),
            64'({1'b1, pd, pu, pl}));
      if (q[0].gap) begin
        chk("gap_tvalid", 64'(bus.tvalid), 64'(0));
        chk("gap_busy", 64'(ctl_busy), 64'(1));
        void'(q.pop_front());
        pv = 1'b0;
        bus.tready = rnd ? ($urandom_range(99) >= 12) : 1'b1;
      end else begin
        chk("tvalid", 64'(bus.tvalid), 64'(1));
        chk("tdata", 64'(bus.tdata), 64'(q[0].data));
        chk("tuser", 64'(bus.tuser), 64'(q[0].user));
        chk("tlast", 64'(bus.tlast), 64'(q[0].last));
        chk("busy", 64'(ctl_busy), 64'(1));
        rdy = rnd ? ($urandom_range(99) >= 12) : 1'b1;
        bus.tready = rdy;
        pv = bus.tvalid; pr = rdy;
        pd = bus.tdata; pu = bus.tuser; pl = bus.tlast;
        pend = 1'b0;
        if (rdy) begin
          pend = q[0].eof;
          void'(q.pop_front());
          pops++;
        end
      end
      @(negedge aclk);
      cyc++;
      if (pend) begin
        exp_idx = exp_idx + 8'd1;
        pend    = 1'b0;
      end
    end
    chk("drained_within_budget", 64'(q.size()), 64'(0));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},   64'(ctl_busy),   64'(0));
    chk({tag, "_tvalid"}, 64'(bus.tvalid), 64'(0));
  endtask

  initial begin
`ifdef VDMA_PATTERN_GAP_EN
    gap_build = 1'b1;
`else
    gap_build = 1'b0;
`endif
    areset = 1'b1; ctl_enable = 1'b0; ctl_update = 1'b0;
    param_width = '0; param_height = '0; param_mode = '0;
    param_color = '0; param_h_gap = '0; bus.tready = 1'b0;
    exp_idx = 8'd0;
    lat_w = 0; lat_h = 0; lat_mode = 0; lat_color = '0; lat_gap = 0;
    repeat (3) @(negedge aclk);

    // Reset state
    chk("rst_tvalid", 64'(bus.tvalid), 64'(0));
    chk("rst_tuser",  64'(bus.tuser),  64'(0));
    chk("rst_tlast",  64'(bus.tlast),  64'(0));
    chk("rst_tdata",  64'(bus.tdata),  64'(0));
    chk("rst_busy",   64'(ctl_busy),   64'(0));
    chk("rst_index",  64'(ctl_index),  64'(0));
    areset = 1'b0;
    @(negedge aclk);

    // Unconfigured (all-zero latched) enable stays idle
    ctl_enable = 1'b1;
    repeat (3) begin @(negedge aclk); chk_idle("unconfigured"); end
    ctl_enable = 1'b0;

    // 4x2 coordinate pattern, single enable pulse
    start(4, 2, 1, 32'h0, 0, 1'b1, 1'b0, 1);
    run(100, 1'b0, -1, -1);
    chk("coord_index", 64'(ctl_index), 64'(1));
    chk_idle("coord_end");

    // Update=0 reuses the latched 4x2 coordinate set despite new pin values
    start(7, 5, 2, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 1);
    run(100, 1'b0, -1, -1);
    chk_idle("reuse_end");

    // Pixel counter with random backpressure
    start(40, 30, 0, 32'h0, 0, 1'b1, 1'b0, 1);
    run(5000, 1'b1, -1, -1);
    chk_idle("counter_end");

    // Checkerboard with random backpressure
    start(36, 20, 3, 32'h0, 0, 1'b1, 1'b0, 1);
    run(3000, 1'b1, -1, -1);
    chk_idle("checker_end");

    // Random geometry / mode / colour / gap
    for (int i = 0; i < 4; i++) begin
      start($urandom_range(20, 1), $urandom_range(6, 1), $urandom_range(3, 0),
            $urandom, $urandom_range(3, 0), 1'b1, 1'b0, 1);
      run(1000, 1'b1, -1, -1);
      chk_idle("random_end");
    end

    // Line gap of 3 (idle cycles expected only in the gap build)
    start(4, 2, 0, 32'h0, 3, 1'b1, 1'b0, 1);
    run(100, 1'b0, -1, -1);
    chk_idle("gap_end");

    // 1x1 frames back-to-back with enable held; index wraps past 255
    start(1, 1, 2, 32'hA5A5_A5A5, 0, 1'b1, 1'b1, 300);
    run(400, 1'b0, 299, -1);
    chk_idle("b2b_end");

    // Enable dropped at beat 5 of a 4x4 frame: whole frame still emitted
    start(4, 4, 0, 32'h0, 0, 1'b1, 1'b1, 1);
    run(100, 1'b0, 5, -1);
    chk_idle("drop_end");

    // Zero width never starts
    param_width = '0; param_height = VW'(4); ctl_update = 1'b1; ctl_enable = 1'b1;
    repeat (5) begin @(negedge aclk); chk_idle("zero_width"); end
    ctl_update = 1'b0; ctl_enable = 1'b0;

    // Reset at beat 6 of a 4x4 frame, then a fresh frame
    start(4, 4, 1, 32'h0, 0, 1'b1, 1'b0, 1);
    run(100, 1'b0, -1, 6);
    areset = 1'b1;
    #1;
    chk("abort_tvalid", 64'(bus.tvalid), 64'(0));
    chk("abort_tuser",  64'(bus.tuser),  64'(0));
    chk("abort_tlast",  64'(bus.tlast),  64'(0));
    chk("abort_tdata",  64'(bus.tdata),  64'(0));
    chk("abort_busy",   64'(ctl_busy),   64'(0));
    chk("abort_index",  64'(ctl_index),  64'(0));
    q.delete();
    exp_idx = 8'd0;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    start(4, 4, 1, 32'h0, 0, 1'b1, 1'b0, 1);
    chk("restart_tuser", 64'(bus.tuser), 64'(1));
    chk("restart_tdata", 64'(bus.tdata), 64'(0));
    run(100, 1'b0, -1, -1);
    chk("restart_index", 64'(ctl_index), 64'(1));
    chk_idle("restart_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
